accumulator_packet_reader: RTL and testbench

//  Drains summed 16-bit samples from the accumulator's first-word-fall-through output FIFO and frames them into a byte stream for the UART transmitter.

---
 rtl/accumulator_packet_reader.sv | 166 ++++++++++++++++
 tb/tb_accumulator_packet_reader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/accumulator_packet_reader.sv
`default_nettype none
// ============================================================================
// Module   : accumulator_packet_reader
// Brief    : Frames FWFT FIFO samples into SYNC/SEQ/payload/CSUM UART bytes.
// Revision : 1.0 - initial release
// ============================================================================
module accumulator_packet_reader #(
  parameter int         WORDS_PER_PACKET = 125,
  parameter logic [7:0] SYNC_BYTE        = 8'hA5,
  parameter int         TIMEOUT_CYCLES   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] data_in,
  input  logic        data_empty,
  output logic        data_rd,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        underrun
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_SEQ  = 3'd2,
    ST_HIGH = 3'd3,
    ST_LOW  = 3'd4,
    ST_CSUM = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    seq_q, seq_d;
  logic [7:0]    csum_q, csum_d;
  logic [7:0]    word_cnt_q, word_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          aborted_q, aborted_d;
  logic          underrun_q, underrun_d;
  logic          start_ok;
  logic [7:0]    csum_neg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      seq_q      <= 8'h00;
      csum_q     <= 8'h00;
      word_cnt_q <= 8'h00;
      tmo_q      <= '0;
      aborted_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      seq_q      <= seq_d;
      csum_q     <= csum_d;
      word_cnt_q <= word_cnt_d;
      tmo_q      <= tmo_d;
      aborted_q  <= aborted_d;
      underrun_q <= underrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    seq_d      = seq_q;
    csum_d     = csum_q;
    word_cnt_d = word_cnt_q;
    tmo_d      = tmo_q;
    aborted_d  = aborted_q;
    underrun_d = underrun_q;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    start_ok   = enable & ~data_empty;
    csum_neg   = 8'h00 - csum_q;

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d    = ST_SYNC;
          csum_d     = 8'h00;
          word_cnt_d = 8'h00;
          tmo_d      = '0;
          aborted_d  = 1'b0;
        end
      end
      ST_SYNC: begin
        tx_valid = 1'b1;
        tx_data  = SYNC_BYTE;
        if (tx_ready) begin
          state_d = ST_SEQ;
          tmo_d   = '0;
        end
      end
      ST_SEQ: begin
        tx_valid = 1'b1;
        tx_data  = seq_q;
        if (tx_ready) begin
          state_d = ST_HIGH;
          tmo_d   = '0;
        end
      end
      ST_HIGH: begin
        tx_valid = ~data_empty;
        tx_data  = data_in[15:8];
        if (data_empty) begin
          // Starved mid-packet: give up and close with an inverted checksum.
          if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d    = ST_CSUM;
            aborted_d  = 1'b1;
            underrun_d = 1'b1;
            tmo_d      = '0;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end else if (tx_ready) begin
          state_d = ST_LOW;
          csum_d  = csum_q + data_in[15:8];
          tmo_d   = '0;
        end
      end
      ST_LOW: begin
        tx_valid = 1'b1;
        tx_data  = data_in[7:0];
        if (tx_ready) begin
          csum_d     = csum_q + data_in[7:0];
          word_cnt_d = word_cnt_q + 8'd1;
          tmo_d      = '0;
          if (word_cnt_q == 8'(WORDS_PER_PACKET - 1)) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_HIGH;
          end
        end
      end
      ST_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = aborted_q ? ~csum_neg : csum_neg;
        if (tx_ready) begin
          seq_d = seq_q + 8'd1;
          tmo_d = '0;
          // Chain straight into the next packet so there is no idle gap.
          if (start_ok) begin
            state_d    = ST_SYNC;
            csum_d     = 8'h00;
            word_cnt_d = 8'h00;
            aborted_d  = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign data_rd  = (state_q == ST_LOW) & tx_ready & ~data_empty & ~rst;
  assign busy     = (state_q != ST_IDLE);
  assign underrun = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_accumulator_packet_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_accumulator_packet_reader
// Brief    : Packet-level reference model bench for accumulator_packet_reader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_accumulator_packet_reader;

  localparam int W    = 2;
  localparam int TMO  = 8;
  localparam int LAST = 2 * W + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] data_in = 16'h0;
  logic        data_empty = 1'b1;
  logic        data_rd;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        busy;
  logic        underrun;

  accumulator_packet_reader #(
    .WORDS_PER_PACKET(W),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .data_in(data_in),
    .data_empty(data_empty), .data_rd(data_rd), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] fifo[$];
  logic [7:0]  got[$];
  bit          pop_pending = 0;
  int          rd_cnt = 0, busy_cnt = 0, vcnt = 0;
  logic        s_valid, s_rd;
  logic [7:0]  s_data;

  // Packet model: byte index k walks SYNC, SEQ, payload bytes, CSUM.
  int          k = 0;
  int          m_ecnt = 0;
  bit          m_busy = 0, m_abort = 0, m_under = 0;
  logic [7:0]  m_seq = 8'h00, m_sum = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_cycle();
    logic       exp_v, exp_rd, hi_slot;
    logic [7:0] exp_d;
    s_valid = tx_valid; s_data = tx_data; s_rd = data_rd;
    pop_pending = data_rd;
    if (data_rd)  rd_cnt++;
    if (busy)     busy_cnt++;
    if (tx_valid) vcnt++;
    if (tx_valid && tx_ready && !rst) got.push_back(tx_data);
    if (rst) begin
      chk("rd_during_rst", data_rd, 0);
      m_busy = 0; m_seq = 8'h00; m_under = 0;
    end else begin
      exp_v = 0; exp_rd = 0; hi_slot = 0; exp_d = 8'h00;
      if (m_busy) begin
        if (k == 0) begin
          exp_v = 1; exp_d = 8'hA5;
        end else if (k == 1) begin
          exp_v = 1; exp_d = m_seq;
        end else if (k == LAST) begin
          exp_v = 1;
          exp_d = m_abort ? ~(8'h00 - m_sum) : (8'h00 - m_sum);
        end else if (((k - 2) % 2) == 0) begin
          hi_slot = 1; exp_v = !data_empty; exp_d = data_in[15:8];
        end else begin
          exp_v = 1; exp_d = data_in[7:0]; exp_rd = tx_ready;
        end
      end
      chk("busy", busy, m_busy);
      chk("underrun", underrun, m_under);
      chk("tx_valid", tx_valid, exp_v);
      chk("data_rd", data_rd, exp_rd);
      if (exp_v) chk("tx_data", tx_data, exp_d);

      if (!m_busy) begin
        if (enable && !data_empty) begin
          m_busy = 1; k = 0; m_sum = 8'h00; m_abort = 0; m_ecnt = 0;
        end
      end else if (hi_slot && data_empty) begin
        m_ecnt++;
        if (m_ecnt == TMO) begin
          k = LAST; m_abort = 1; m_under = 1; m_ecnt = 0;
        end
      end else if (exp_v && tx_ready) begin
        m_ecnt = 0;
        if (k >= 2 && k < LAST) m_sum = m_sum + exp_d;
        if (k == LAST) begin
          m_seq  = m_seq + 8'd1;
          m_busy = 0;
          if (enable && !data_empty) begin
            m_busy = 1; k = 0; m_sum = 8'h00; m_abort = 0;
          end
        end else begin
          k++;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic en, input logic rdy,
                      input logic push, input logic [15:0] w);
    @(posedge clk);
    #1;
    if (pop_pending && fifo.size() > 0) void'(fifo.pop_front());
    if (push) fifo.push_back(w);
    rst = r; enable = en; tx_ready = rdy;
    data_empty = (fifo.size() == 0);
    data_in    = data_empty ? 16'h0 : fifo[0];
    @(negedge clk);
    check_cycle();
  endtask

  task automatic do_reset();
    fifo.delete();
    step(1, 0, 0, 0, 16'h0);
    step(1, 0, 0, 0, 16'h0);
    step(0, 0, 0, 0, 16'h0);
    chk("reset_busy", busy, 0);
    chk("reset_underrun", underrun, 0);
    chk("reset_tx_valid", s_valid, 0);
    chk("reset_data_rd", s_rd, 0);
  endtask

  initial begin
    logic [7:0] e1 [7] = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h00, 8'hFF, 8'hBB};
    logic [7:0] e4 [5] = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h02};
    int g0, r0, b0, v0, gap;
    logic rr, ee, yy;

    // Basic packet, full rate
    do_reset();
    g0 = got.size(); r0 = rd_cnt; b0 = busy_cnt;
    step(0, 1, 1, 1, 16'h1234);
    step(0, 1, 1, 1, 16'h00FF);
    for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 16'h0);
    chk("t1_len", got.size() - g0, 7);
    for (int i = 0; i < 7; i++) chk("t1_byte", got[g0 + i], e1[i]);
    chk("t1_rd_pulses", rd_cnt - r0, 2);
    chk("t1_busy_cycles", busy_cnt - b0, 7);

    // Same data, tx_ready toggling
    do_reset();
    g0 = got.size();
    step(0, 1, 1, 1, 16'h1234);
    step(0, 1, 0, 1, 16'h00FF);
    for (int i = 0; i < 28; i++) step(0, 1, ((i % 2) == 0), 0, 16'h0);
    chk("t2_len", got.size() - g0, 7);
    for (int i = 0; i < 7; i++) chk("t2_byte", got[g0 + i], e1[i]);

    // 257 back-to-back packets: seq wraps, no idle gaps
    do_reset();
    g0 = got.size(); b0 = busy_cnt;
    for (int i = 0; i < 1799; i++)
      step(0, 1, 1, (fifo.size() < 4), 16'($urandom));
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 16'h0);
    chk("t3_len", got.size() - g0, 257 * 7);
    chk("t3_busy_cycles", busy_cnt - b0, 257 * 7);
    chk("t3_seq_first", got[g0 + 1], 8'h00);
    chk("t3_seq_255", got[g0 + 255 * 7 + 1], 8'hFF);
    chk("t3_seq_wrap", got[g0 + 256 * 7 + 1], 8'h00);

    // Timeout abort
    do_reset();
    g0 = got.size(); r0 = rd_cnt;
    step(0, 1, 1, 1, 16'h0102);
    for (int i = 0; i < 24; i++) step(0, 1, 1, 0, 16'h0);
    chk("t4_len", got.size() - g0, 5);
    for (int i = 0; i < 5; i++) chk("t4_byte", got[g0 + i], e4[i]);
    chk("t4_underrun", underrun, 1);
    chk("t4_rd_pulses", rd_cnt - r0, 1);

    // Reset during LOW byte of word 0
    do_reset();
    step(0, 1, 1, 1, 16'hBEEF);
    step(0, 1, 1, 1, 16'h4321);
    step(0, 1, 1, 0, 16'h0);
    step(0, 1, 1, 0, 16'h0);
    step(1, 1, 1, 0, 16'h0);
    chk("t5_rd_in_rst", s_rd, 0);
    step(0, 0, 1, 0, 16'h0);
    chk("t5_valid_after", s_valid, 0);
    chk("t5_fifo_kept", fifo.size(), 2);
    g0 = got.size();
    for (int i = 0; i < 16; i++) step(0, 1, 1, 0, 16'h0);
    chk("t5_len", got.size() - g0, 7);
    chk("t5_seq", got[g0 + 1], 8'h00);
    chk("t5_hi0", got[g0 + 2], 8'hBE);

    // enable gating
    do_reset();
    v0 = vcnt; r0 = rd_cnt;
    step(0, 0, 1, 1, 16'h5A5A);
    for (int i = 0; i < 9; i++) step(0, 0, 1, 0, 16'h0);
    chk("t6_no_valid", vcnt - v0, 0);
    chk("t6_no_rd", rd_cnt - r0, 0);
    step(0, 1, 1, 0, 16'h0);
    step(0, 1, 1, 0, 16'h0);
    chk("t6_start_valid", s_valid, 1);
    chk("t6_start_sync", s_data, 8'hA5);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 16'h0);

    // Randomized traffic against the model
    do_reset();
    gap = 0;
    for (int i = 0; i < 3000; i++) begin
      rr = ($urandom_range(0, 399) == 0);
      ee = ($urandom_range(0, 9) < 8);
      yy = ($urandom_range(0, 9) < 7);
      if (gap == 0 && fifo.size() < 6) begin
        step(rr, ee, yy, 1, 16'($urandom));
        gap = ($urandom_range(0, 19) == 0) ? $urandom_range(9, 14) : $urandom_range(0, 2);
      end else begin
        if (gap > 0) gap--;
        step(rr, ee, yy, 0, 16'h0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
